// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - hh:mm:ss timekeeping controller with button-driven set mode
//
// Sequences the time-of-day counters from the 1 Hz TIMER carry and lets the
// user set hour, minute and second with debounced button pulses.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   one-cycle pulse per second from the TIMER
//   btn_mode   in   one-cycle pulse, advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
//   btn_inc    in   one-cycle pulse, increments the selected field in set mode
//   hour       out  current hour 0..23
//   min        out  current minute 0..59
//   sec        out  current second 0..59
//   mode       out  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   blink      out  blink phase for the field being set
//   timer_rst  out  reset pulse to the TIMER
//   day_pulse  out  one-cycle pulse on 23:59:59 -> 00:00:00
module clock_ctrl #(
    parameter logic [4:0] INIT_HOUR   = 5'd0,
    parameter logic [5:0] INIT_MIN    = 6'd0,
    parameter logic [5:0] INIT_SEC    = 6'd0,
    parameter logic [7:0] BLINK_TICKS = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       blink,
    output logic       timer_rst,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] blink_cnt;
    logic       rst_q;

    logic in_set;
    logic enter_set;
    logic exit_set;
    logic run_tick;
    logic do_inc;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;
    logic blink_due;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (btn_mode) begin
            case (state)
                RUN:      state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = SET_MIN;
                SET_MIN:  state_nxt = SET_SEC;
                default:  state_nxt = RUN;
            endcase
        end
    end

    // Decode of state and inputs feeding the registered datapath
    always_comb begin
        in_set    = (state != RUN);
        enter_set = (state == RUN) && btn_mode;
        exit_set  = (state == SET_SEC) && btn_mode;
        run_tick  = (state == RUN) && tick;
        // btn_mode takes priority over btn_inc in set states
        do_inc    = in_set && btn_inc && !btn_mode;
        sec_wrap  = (sec == 6'd59);
        min_wrap  = (min == 6'd59);
        hour_wrap = (hour == 5'd23);
        blink_due = (blink_cnt == BLINK_TICKS - 8'd1);
    end

    assign mode = state;

    // Remembers that reset was asserted on the previous edge so timer_rst
    // stretches one cycle past the release of rst.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour      <= INIT_HOUR;
            min       <= INIT_MIN;
            sec       <= INIT_SEC;
            blink     <= 1'b0;
            blink_cnt <= 8'd0;
            day_pulse <= 1'b0;
            timer_rst <= 1'b1;
        end else begin
            day_pulse <= 1'b0;
            // Leaving set mode re-arms the TIMER so the next second is full length
            timer_rst <= rst_q | exit_set;

            if (run_tick) begin
                sec <= sec_wrap ? 6'd0 : sec + 6'd1;
                if (sec_wrap) begin
                    min <= min_wrap ? 6'd0 : min + 6'd1;
                    if (min_wrap) begin
                        hour <= hour_wrap ? 5'd0 : hour + 5'd1;
                    end
                end
                day_pulse <= sec_wrap && min_wrap && hour_wrap;
            end

            // Field increments wrap locally and never carry
            if (do_inc) begin
                case (state)
                    SET_HOUR: hour <= hour_wrap ? 5'd0 : hour + 5'd1;
                    SET_MIN:  min  <= min_wrap ? 6'd0 : min + 6'd1;
                    SET_SEC:  sec  <= sec_wrap ? 6'd0 : sec + 6'd1;
                    default:  ;
                endcase
            end

            if (enter_set) begin
                blink     <= 1'b1;
                blink_cnt <= 8'd0;
            end else if (exit_set || !in_set) begin
                blink     <= 1'b0;
                blink_cnt <= 8'd0;
            end else if (tick) begin
                if (blink_due) begin
                    blink     <= ~blink;
                    blink_cnt <= 8'd0;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Timekeeping controller for the digital clock: consumes the 1 Hz carry pulse of the base TIMER and sequences the hh:mm:ss counters.
- Provides a user set mode (hour/minute/second) driven by debounced button pulses.
- Re-arms the TIMER on leaving set mode so the first second after setting is full length.
- Sits between the TIMER instance and the display/segment driver.

Parameters:
- INIT_HOUR, 5'd0, hour value loaded on reset (0..23)
- INIT_MIN, 6'd0, minute value loaded on reset (0..59)
- INIT_SEC, 6'd0, second value loaded on reset (0..59)
- BLINK_TICKS, 8'd1, number of ticks between blink toggles in set mode (must be >=1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse per second (TIMER cy)
- btn_mode  in  1  one-cycle pulse; advances mode
- btn_inc  in  1  one-cycle pulse; increments selected field in set mode
- hour  out  5  current hour, 0..23
- min  out  6  current minute, 0..59
- sec  out  6  current second, 0..59
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
- blink  out  1  display blink phase for the selected field
- timer_rst  out  1  one-cycle pulse to the TIMER rst input
- day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - hour=INIT_HOUR, min=INIT_MIN, sec=INIT_SEC, mode=RUN.
  - blink=0, day_pulse=0, blink counter=0.
  - timer_rst=1 while rst is held, and for exactly one cycle after rst deasserts.
  - Reset mid-set-mode aborts setting and discards any partial edits.
- Latency: all outputs are registered. An input sampled at edge N is reflected in the outputs after edge N; no combinational input-to-output paths.
- FSM transitions on btn_mode: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
- On the SET_SEC->RUN transition: timer_rst=1 for exactly one cycle, and the blink counter clears.
- RUN:
  - tick increments sec. 59->0 carries into min; min 59->0 carries into hour; hour 23->0.
  - All carries resolve at the same edge.
  - day_pulse=1 for one cycle on 23:59:59->00:00:00.
  - btn_inc is ignored.
- Set states:
  - tick does not advance time; it only drives blink.
  - btn_inc increments the selected field only, wrapping 23->0 (hour) or 59->0 (min/sec).
  - A wrap never carries into other fields and never raises day_pulse.
- blink:
  - In RUN, blink=0.
  - In set states, blink toggles when the blink counter reaches BLINK_TICKS-1 on a tick; the counter then clears.
  - Entering SET_HOUR from RUN sets blink=1 (field visible-highlighted) with the counter at 0.
- Simultaneous events:
  - tick and btn_mode in RUN: the tick is applied (including carries/day_pulse) and mode advances to SET_HOUR at the same edge.
  - btn_mode and btn_inc in a set state: btn_mode wins and btn_inc is dropped.
  - btn_mode in SET_SEC together with a tick: the tick is ignored for time, and timer_rst pulses.
- Out-of-range values cannot occur: there is no load path other than reset and btn_inc.

Test Plan:
- Reset: hold rst 3 cycles then release -> 00:00:00, mode=0, blink=0, day_pulse=0; timer_rst high during rst plus exactly 1 cycle after.
- Carry chain: reach 23:59:58 via set mode, return to RUN, apply 2 ticks -> 23:59:59, then 00:00:00 with day_pulse high for exactly 1 cycle.
- Set sequence: from 10:20:30 press mode, inc×15, mode, inc×45, mode, inc×31, mode -> hour=1, min=5, sec=1. Ticks applied during setting do not change time. timer_rst pulses once on return to RUN; mode sequence is 1,2,3,0.
- Wrap without carry: SET_MIN at min=59, btn_inc -> min=0, hour unchanged, day_pulse=0.
- Simultaneous inputs: tick+btn_mode in RUN at 00:00:59 -> 00:01:00 and mode=1 at the same edge. btn_mode+btn_inc in SET_HOUR -> mode=2, hour unchanged.
- Blink and mid-op reset: with BLINK_TICKS=2 in SET_HOUR, blink toggles every 2nd tick. Assert rst mid-set -> mode=0 and time=INIT values next cycle.
